// File: rtl/sha256_param_engine.sv
// Memory-mapped SHA-256 engine: reads a fixed-length message from word memory, pads it,
// hashes every 512-bit block and writes the eight digest words back to memory.
module sha256_param_engine #(
    parameter int NUM_OF_WORDS     = 20,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int LENGTH_BITS      = NUM_OF_WORDS * 32,
    parameter int MIDSTATE_EN      = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         use_midstate,
    input  logic [255:0] h_in,
    input  logic [15:0]  message_addr,
    input  logic [15:0]  output_addr,
    output logic         busy,
    output logic         done,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data
);
    localparam int NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam int BLK_W      = $clog2(NUM_BLOCKS + 1);
    localparam int R          = ROUNDS_PER_CYCLE;
    localparam logic [5:0]  LAST_ROUND = 6'(64 - R);
    localparam logic [31:0] PAD_LEN    = 32'(LENGTH_BITS);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {IDLE, READ, PAD, COMPUTE, UPDATE, WRITE, DONE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Real message words held by block b; zero for trailing padding-only blocks.
    function automatic logic [4:0] words_in_block(input logic [BLK_W-1:0] b);
        int left;
        left = NUM_OF_WORDS - 16 * int'(b);
        if (left >= 16)
            return 5'd16;
        else if (left <= 0)
            return 5'd0;
        else
            return 5'(left);
    endfunction

    state_t             state;
    logic [BLK_W-1:0]   blk;
    logic [4:0]         rd_cnt;
    logic [5:0]         rnd;
    logic [2:0]         wr_idx;
    logic [15:0]        blk_addr;
    logic [15:0]        out_base;
    logic [31:0]        hs [8];
    logic [31:0]        v [8];
    logic [31:0]        w [16];

    logic [4:0]         n_cur;
    logic               last_blk;
    logic [31:0]        w_next [16];
    logic [31:0]        v_next [8];
    logic [31:0]        h_sum [8];

    assign mem_clk  = clk;
    assign n_cur    = words_in_block(blk);
    assign last_blk = (blk == BLK_W'(NUM_BLOCKS - 1));

    always_comb begin
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] nw;
        // NOTE: every comb output gets a default before any conditional use, so no latch can form.
        w_next = w;
        v_next = v;
        t1     = '0;
        t2     = '0;
        nw     = '0;
        // NOTE: blocking assignments let R unrolled rounds chain inside one cycle.
        for (int r = 0; r < R; r++) begin
            t1 = v_next[7] + (rotr(v_next[4], 6) ^ rotr(v_next[4], 11) ^ rotr(v_next[4], 25))
               + ((v_next[4] & v_next[5]) ^ (~v_next[4] & v_next[6])) + K[rnd + 6'(r)] + w_next[0];
            t2 = (rotr(v_next[0], 2) ^ rotr(v_next[0], 13) ^ rotr(v_next[0], 22))
               + ((v_next[0] & v_next[1]) ^ (v_next[0] & v_next[2]) ^ (v_next[1] & v_next[2]));
            nw = (rotr(w_next[14], 17) ^ rotr(w_next[14], 19) ^ (w_next[14] >> 10)) + w_next[9]
               + (rotr(w_next[1], 7) ^ rotr(w_next[1], 18) ^ (w_next[1] >> 3)) + w_next[0];
            v_next[7] = v_next[6];
            v_next[6] = v_next[5];
            v_next[5] = v_next[4];
            v_next[4] = v_next[3] + t1;
            v_next[3] = v_next[2];
            v_next[2] = v_next[1];
            v_next[1] = v_next[0];
            v_next[0] = t1 + t2;
            for (int i = 0; i < 15; i++)
                w_next[i] = w_next[i + 1];
            w_next[15] = nw;
        end
        for (int i = 0; i < 8; i++)
            h_sum[i] = hs[i] + v[i];
    end

    // NOTE: datapath registers carry no reset; the FSM always loads them before they are used.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                for (int i = 0; i < 8; i++)
                    hs[i] <= (MIDSTATE_EN != 0 && use_midstate) ? h_in[255 - 32 * i -: 32] : IV[i];
            end
            READ: if (rd_cnt != 5'd0) w[4'(rd_cnt - 5'd1)] <= mem_read_data;
            PAD: begin
                for (int i = 0; i < 16; i++) begin
                    if (5'(i) >= n_cur) begin
                        if (int'(blk) * 16 + i == NUM_OF_WORDS)
                            w[i] <= 32'h80000000;
                        else if (last_blk && i == 15)
                            w[i] <= PAD_LEN;
                        else
                            w[i] <= 32'h0;
                    end
                end
                v <= hs;
            end
            COMPUTE: begin
                w <= w_next;
                v <= v_next;
            end
            UPDATE: hs <= h_sum;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'h0;
            mem_write_data <= 32'h0;
            blk            <= '0;
            rd_cnt         <= '0;
            rnd            <= '0;
            wr_idx         <= '0;
            blk_addr       <= '0;
            out_base       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy     <= 1'b1;
                    blk      <= '0;
                    rd_cnt   <= '0;
                    blk_addr <= message_addr;
                    out_base <= output_addr;
                    if (words_in_block(BLK_W'(0)) != 5'd0)
                        mem_addr <= message_addr;
                    state    <= READ;
                end
                READ: begin
                    if (rd_cnt == n_cur) begin
                        state <= PAD;
                    end else begin
                        rd_cnt <= rd_cnt + 5'd1;
                        if (rd_cnt + 5'd1 < n_cur)
                            mem_addr <= mem_addr + 16'd1;
                    end
                end
                PAD: begin
                    rnd   <= '0;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    if (rnd == LAST_ROUND)
                        state <= UPDATE;
                    else
                        rnd <= rnd + 6'(R);
                end
                UPDATE: begin
                    if (last_blk) begin
                        mem_we         <= 1'b1;
                        mem_addr       <= out_base;
                        mem_write_data <= h_sum[0];
                        wr_idx         <= '0;
                        state          <= WRITE;
                    end else begin
                        blk      <= blk + BLK_W'(1);
                        rd_cnt   <= '0;
                        blk_addr <= blk_addr + 16'd16;
                        if (words_in_block(blk + BLK_W'(1)) != 5'd0)
                            mem_addr <= blk_addr + 16'd16;
                        state    <= READ;
                    end
                end
                WRITE: begin
                    if (wr_idx == 3'd7) begin
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wr_idx         <= wr_idx + 3'd1;
                        mem_addr       <= mem_addr + 16'd1;
                        mem_write_data <= hs[wr_idx + 3'd1];
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_param_engine.sv
// Scoreboard bench for sha256_param_engine: several parameterisations share one word memory;
// expected digest writes are queued at start and popped by an independent write monitor.
module tb_sha256_param_engine;
    localparam int NI = 7;
    localparam logic [255:0] IV_ALL = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        int          inst;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        start [NI];
    logic        use_mid [NI];
    logic [15:0] maddr [NI];
    logic [15:0] oaddr [NI];
    logic        busy [NI];
    logic        done [NI];
    logic        mclk [NI];
    logic        we [NI];
    logic [15:0] addr [NI];
    logic [31:0] wdata [NI];
    logic [31:0] rdata [NI];
    logic [255:0] mid_h;
    logic [255:0] zero_h;
    logic [31:0] mem [65536];
    wr_t         exp_q [$];
    int          n_checks;
    int          n_errors;

    sha256_param_engine #(.NUM_OF_WORDS(0), .ROUNDS_PER_CYCLE(1)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .use_midstate(use_mid[0]), .h_in(zero_h),
        .message_addr(maddr[0]), .output_addr(oaddr[0]), .busy(busy[0]), .done(done[0]), .mem_clk(mclk[0]),
        .mem_we(we[0]), .mem_addr(addr[0]), .mem_write_data(wdata[0]), .mem_read_data(rdata[0]));
    sha256_param_engine #(.NUM_OF_WORDS(14), .ROUNDS_PER_CYCLE(2)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .use_midstate(use_mid[1]), .h_in(zero_h),
        .message_addr(maddr[1]), .output_addr(oaddr[1]), .busy(busy[1]), .done(done[1]), .mem_clk(mclk[1]),
        .mem_we(we[1]), .mem_addr(addr[1]), .mem_write_data(wdata[1]), .mem_read_data(rdata[1]));
    sha256_param_engine #(.NUM_OF_WORDS(20), .ROUNDS_PER_CYCLE(1)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .use_midstate(use_mid[2]), .h_in(zero_h),
        .message_addr(maddr[2]), .output_addr(oaddr[2]), .busy(busy[2]), .done(done[2]), .mem_clk(mclk[2]),
        .mem_we(we[2]), .mem_addr(addr[2]), .mem_write_data(wdata[2]), .mem_read_data(rdata[2]));
    sha256_param_engine #(.NUM_OF_WORDS(20), .ROUNDS_PER_CYCLE(4)) u3 (
        .clk(clk), .reset_n(reset_n), .start(start[3]), .use_midstate(use_mid[3]), .h_in(zero_h),
        .message_addr(maddr[3]), .output_addr(oaddr[3]), .busy(busy[3]), .done(done[3]), .mem_clk(mclk[3]),
        .mem_we(we[3]), .mem_addr(addr[3]), .mem_write_data(wdata[3]), .mem_read_data(rdata[3]));
    sha256_param_engine #(.NUM_OF_WORDS(13), .ROUNDS_PER_CYCLE(2)) u4 (
        .clk(clk), .reset_n(reset_n), .start(start[4]), .use_midstate(use_mid[4]), .h_in(zero_h),
        .message_addr(maddr[4]), .output_addr(oaddr[4]), .busy(busy[4]), .done(done[4]), .mem_clk(mclk[4]),
        .mem_we(we[4]), .mem_addr(addr[4]), .mem_write_data(wdata[4]), .mem_read_data(rdata[4]));
    sha256_param_engine #(.NUM_OF_WORDS(4), .ROUNDS_PER_CYCLE(1), .LENGTH_BITS(640), .MIDSTATE_EN(1)) u5 (
        .clk(clk), .reset_n(reset_n), .start(start[5]), .use_midstate(use_mid[5]), .h_in(mid_h),
        .message_addr(maddr[5]), .output_addr(oaddr[5]), .busy(busy[5]), .done(done[5]), .mem_clk(mclk[5]),
        .mem_we(we[5]), .mem_addr(addr[5]), .mem_write_data(wdata[5]), .mem_read_data(rdata[5]));
    sha256_param_engine #(.NUM_OF_WORDS(20), .ROUNDS_PER_CYCLE(2)) u6 (
        .clk(clk), .reset_n(reset_n), .start(start[6]), .use_midstate(use_mid[6]), .h_in(zero_h),
        .message_addr(maddr[6]), .output_addr(oaddr[6]), .busy(busy[6]), .done(done[6]), .mem_clk(mclk[6]),
        .mem_we(we[6]), .mem_addr(addr[6]), .mem_write_data(wdata[6]), .mem_read_data(rdata[6]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory with one-cycle read latency, one read port per engine.
    always @(posedge clk)
        for (int k = 0; k < NI; k++)
            rdata[k] <= mem[addr[k]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain FIPS 180-4 compression with a full 64-word schedule.
    function automatic logic [255:0] compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0] s [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++)
            s[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++)
            s[t] = (rr(s[t-2], 17) ^ rr(s[t-2], 19) ^ (s[t-2] >> 10)) + s[t-7]
                 + (rr(s[t-15], 7) ^ rr(s[t-15], 18) ^ (s[t-15] >> 3)) + s[t-16];
        {a, b, c, d, e, f, g, h} = hv;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + s[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hv[255:224] + a, hv[223:192] + b, hv[191:160] + c, hv[159:128] + d,
                hv[127:96] + e, hv[95:64] + f, hv[63:32] + g, hv[31:0] + h};
    endfunction

    function automatic logic [255:0] model_hash(input logic [15:0] base, input int nw);
        logic [255:0] hv;
        logic [511:0] blk;
        logic [31:0]  word;
        int nb;
        int gi;
        hv = IV_ALL;
        nb = (nw + 2) / 16 + 1;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 16; i++) begin
                gi = 16 * b + i;
                if (gi < nw)       word = mem[16'(base + 16'(gi))];
                else if (gi == nw) word = 32'h80000000;
                else               word = 32'h0;
                if (b == nb - 1 && i == 15) word = 32'(nw * 32);
                blk[511 - 32 * i -: 32] = word;
            end
            hv = compress(hv, blk);
        end
        return hv;
    endfunction

    // Write monitor: every mem_we cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (we[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {15'(k), we[k], addr[k], wdata[k]}, 64'h0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("digest_write", {16'(k), addr[k], wdata[k]}, {16'(e.inst), e.addr, e.data});
                end
            end
        end
    end

    task automatic check_reset(input int k);
        check("reset_outputs", {13'h0, busy[k], done[k], we[k], addr[k], wdata[k]}, 64'h0);
    endtask

    task automatic run_hash(input int k, input logic [15:0] ma, input logic [15:0] oa,
                            input logic [255:0] dig, input int lat, input bit hold);
        int cyc;
        bit seen;
        for (int i = 0; i < 8; i++) begin
            wr_t e;
            e.inst = k;
            e.addr = 16'(oa + 16'(i));
            e.data = dig[255 - 32 * i -: 32];
            exp_q.push_back(e);
        end
        maddr[k] = ma;
        oaddr[k] = oa;
        start[k] = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < lat + 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_after_start", 64'(busy[k]), 64'h1);
            if (!hold) start[k] = 1'b0;
            if (done[k] === 1'b1) seen = 1'b1;
        end
        start[k] = 1'b0;
        check("start_to_done", 64'(cyc), 64'(lat));
        check("busy_at_done", 64'(busy[k]), 64'h0);
        repeat (20) @(negedge clk);
        check("single_hash", {31'h0, busy[k], 32'(exp_q.size())}, 64'h0);
    endtask

    initial begin
        logic [255:0] d20;
        logic [255:0] d13;
        logic [511:0] blk0;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        zero_h   = '0;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0; use_mid[k] = 1'b0; maddr[k] = '0; oaddr[k] = '0;
        end
        for (int i = 0; i < 65536; i++) mem[i] = 32'hA5A50000 | 32'(i);
        for (int i = 0; i < 20; i++) mem[16'h0100 + i] = $urandom;
        mem[16'h0200] = 32'h61626364; mem[16'h0201] = 32'h62636465; mem[16'h0202] = 32'h63646566;
        mem[16'h0203] = 32'h64656667; mem[16'h0204] = 32'h65666768; mem[16'h0205] = 32'h66676869;
        mem[16'h0206] = 32'h6768696a; mem[16'h0207] = 32'h68696a6b; mem[16'h0208] = 32'h696a6b6c;
        mem[16'h0209] = 32'h6a6b6c6d; mem[16'h020a] = 32'h6b6c6d6e; mem[16'h020b] = 32'h6c6d6e6f;
        mem[16'h020c] = 32'h6d6e6f70; mem[16'h020d] = 32'h6e6f7071;
        d20 = model_hash(16'h0100, 20);
        d13 = model_hash(16'h0100, 13);
        for (int i = 0; i < 16; i++) blk0[511 - 32 * i -: 32] = mem[16'h0100 + i];
        mid_h = compress(IV_ALL, blk0);
        use_mid[5] = 1'b1;

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) check_reset(k);
        check("mem_clk_follows_clk", 64'(mclk[2]), 64'(clk));
        reset_n = 1'b1;
        @(negedge clk);

        run_hash(0, 16'h0300, 16'h1000, DIG_EMPTY, 76, 1'b0);
        run_hash(1, 16'h0200, 16'h1010, DIG_448, 93, 1'b0);
        run_hash(2, 16'h0100, 16'h1020, d20, 163, 1'b0);
        run_hash(6, 16'h0100, 16'h1030, d20, 99, 1'b0);
        run_hash(3, 16'h0100, 16'h1040, d20, 67, 1'b0);
        run_hash(4, 16'h0100, 16'h1050, d13, 57, 1'b0);
        run_hash(5, 16'h0110, 16'h1060, d20, 80, 1'b0);

        // Abort a hash mid-COMPUTE; the monitor flags any write from it.
        maddr[2] = 16'h0100;
        oaddr[2] = 16'h2000;
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_before_abort", 64'(busy[2]), 64'h1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset(2);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_after_abort", 64'(busy[2]), 64'h0);
        run_hash(2, 16'h0100, 16'h2000, d20, 163, 1'b0);

        // start held through done, digest wraps past 16'hFFFF.
        run_hash(2, 16'h0100, 16'hFFFE, d20, 163, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
